// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the multi-pad NES/SNES serial reader.
package nes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } pad_state_e;

    localparam int NES_BITS  = 8;
    localparam int SNES_BITS = 16;

    // Button positions in an NES word (bit 0 is shifted out first)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_channel.sv
// One pad's data path: input synchroniser, per-bit sample register and
// published button word with one-cycle pressed/released edge pulses.
module nes_pad_channel #(
    parameter int NUM_BITS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pad_data_i,
    input  logic                sample_i,
    input  logic [IDX_W-1:0]    bit_idx_i,
    input  logic                publish_i,
    output logic [NUM_BITS-1:0] buttons_o,
    output logic [NUM_BITS-1:0] pressed_o,
    output logic [NUM_BITS-1:0] released_o
);

    logic [1:0]          sync_q, sync_d;
    logic [NUM_BITS-1:0] sample_q, sample_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic [NUM_BITS-1:0] pressed_q, pressed_d;
    logic [NUM_BITS-1:0] released_q, released_d;

    always_comb begin
        sync_d     = {sync_q[0], pad_data_i};
        sample_d   = sample_q;
        buttons_d  = buttons_q;
        pressed_d  = '0;
        released_d = '0;
        if (sample_i) begin
            sample_d[bit_idx_i] = sync_q[1];
        end
        // Line is active-low: a sampled 0 means the button is held
        if (publish_i) begin
            buttons_d  = ~sample_q;
            pressed_d  = ~sample_q & ~buttons_q;
            released_d = sample_q & buttons_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sample_q   <= '0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            sync_q     <= sync_d;
            sample_q   <= sample_d;
            buttons_q  <= buttons_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign buttons_o  = buttons_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/nes_pad_reader.sv
// Multi-pad serial gamepad reader: shared latch/clock sequencer with one
// nes_pad_channel per pad, publishing a button frame every POLL_CYCLES.
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int HALF_PERIOD = 256,
    parameter int POLL_CYCLES = 524288
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         valid
);

    localparam int TICK_W = $clog2(HALF_PERIOD);
    localparam int IDX_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int POLL_W = $clog2(POLL_CYCLES);

    pad_state_e        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [POLL_W-1:0] poll_ctr_q, poll_ctr_d;
    logic              pad_latch_q, pad_latch_d;
    logic              pad_clk_q, pad_clk_d;
    logic              valid_q, valid_d;
    logic              tick_end, poll_sat, sample, publish;

    assign tick_end = (tick_q == TICK_W'(HALF_PERIOD - 1));
    assign poll_sat = (poll_ctr_q == POLL_W'(POLL_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        poll_ctr_d = poll_sat ? poll_ctr_q : poll_ctr_q + POLL_W'(1);
        tick_d     = (state_q == IDLE || state_q == DONE || tick_end) ? '0 : tick_q + TICK_W'(1);
        sample     = 1'b0;
        publish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && poll_sat) begin
                    state_d    = LATCH;
                    poll_ctr_d = '0;
                    bit_idx_d  = '0;
                end
            end
            // Latch spans two half-periods; bit_idx doubles as the half counter
            LATCH: begin
                if (tick_end) begin
                    if (bit_idx_q != '0) begin
                        state_d   = CLK_LO;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = IDX_W'(1);
                    end
                end
            end
            CLK_LO: begin
                if (tick_end) begin
                    sample  = 1'b1;
                    state_d = CLK_HI;
                end
            end
            CLK_HI: begin
                if (tick_end) begin
                    if (bit_idx_q == IDX_W'(NUM_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        state_d   = CLK_LO;
                    end
                end
            end
            DONE: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Pad-facing strobes are registered from the next state so they track state_q glitch-free
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != CLK_LO);
        valid_d     = publish;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            poll_ctr_q  <= POLL_W'(POLL_CYCLES - 1);
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            poll_ctr_q  <= poll_ctr_d;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            valid_q     <= valid_d;
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign valid     = valid_q;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        nes_pad_channel #(
            .NUM_BITS (NUM_BITS),
            .IDX_W    (IDX_W)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .pad_data_i (pad_data[p]),
            .sample_i   (sample),
            .bit_idx_i  (bit_idx_q),
            .publish_i  (publish),
            .buttons_o  (buttons[p*NUM_BITS +: NUM_BITS]),
            .pressed_o  (pressed[p*NUM_BITS +: NUM_BITS]),
            .released_o (released[p*NUM_BITS +: NUM_BITS])
        );
    end

endmodule
